// File: rtl/nr4sdm_seq_multiplier.sv
// Sequential radix-4 multiplier consuming an NR4SD- recoded multiplier (7 digits + MB top digit).
// Optional NR4SDM_ZERO_SKIP_EN ends the run early once all remaining digits are zero.
module nr4sdm_seq_multiplier #(
   parameter int BW   = 16,
   parameter int NDIG = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        nm,
   input  logic [6:0]        np,
   input  logic              sign,
   input  logic              one,
   input  logic              two,
   input  logic [BW-1:0]     b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BW+15:0]    p,
   output logic              busy
);

   localparam int PW = BW + 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [2:0]    j;
   logic [6:0]    nm_r;
   logic [6:0]    np_r;
   logic          sign_r;
   logic          one_r;
   logic          two_r;
   logic [BW-1:0] b_r;
   logic [PW-1:0] acc;

   logic [7:0]    nm_ext;
   logic [7:0]    np_ext;
   logic [PW-1:0] b_ext;
   logic [PW-1:0] mag_val;
   logic [PW-1:0] pp;
   logic [PW-1:0] acc_next;
   logic          dig_neg;
   logic          dig_mag1;
   logic          dig_mag2;
   logic          last_digit;

   assign nm_ext = {1'b0, nm_r};
   assign np_ext = {1'b0, np_r};
   assign b_ext  = {{(PW-BW){b_r[BW-1]}}, b_r};

   // Negative digits add the inverted shifted multiple plus a carry-in of one.
   always_comb begin
      dig_neg  = 1'b0;
      dig_mag1 = 1'b0;
      dig_mag2 = 1'b0;
      if (j == 3'(NDIG-1)) begin
         dig_mag2 = two_r;
         dig_mag1 = one_r & ~two_r;
         dig_neg  = sign_r & (one_r | two_r);
      end else begin
         dig_neg  = nm_ext[j];
         dig_mag2 = nm_ext[j] & ~np_ext[j];
         dig_mag1 = np_ext[j];
      end
      mag_val  = dig_mag2 ? (b_ext << 1) : (dig_mag1 ? b_ext : '0);
      pp       = mag_val << {j, 1'b0};
      acc_next = acc + (dig_neg ? ~pp : pp) + {{(PW-1){1'b0}}, dig_neg};
   end

`ifdef NR4SDM_ZERO_SKIP_EN
   logic [7:0] rem_digits;
   assign rem_digits = {one_r | two_r, nm_r | np_r} >> j;
   assign last_digit = (j == 3'(NDIG-1)) || (rem_digits == 8'd0);
`else
   assign last_digit = (j == 3'(NDIG-1));
`endif

   assign in_ready = (state == IDLE);
   assign busy     = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         j         <= '0;
         nm_r      <= '0;
         np_r      <= '0;
         sign_r    <= 1'b0;
         one_r     <= 1'b0;
         two_r     <= 1'b0;
         b_r       <= '0;
         acc       <= '0;
         p         <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  nm_r   <= nm;
                  np_r   <= np;
                  sign_r <= sign;
                  one_r  <= one;
                  two_r  <= two;
                  b_r    <= b;
                  acc    <= '0;
                  j      <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (last_digit) begin
                  p         <= acc_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  j <= j + 3'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nr4sdm_seq_multiplier.sv
// Directed self-checking bench for nr4sdm_seq_multiplier, with its own NR4SD- encoder model.
module tb_nr4sdm_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  nm;
   logic [6:0]  np;
   logic        sign;
   logic        one;
   logic        two;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;
   logic        busy;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   nr4sdm_seq_multiplier #(.BW(16), .NDIG(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .nm(nm), .np(np), .sign(sign), .one(one), .two(two), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
   );

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Carry-propagating recode: each 2-bit slice plus carry maps to a digit in {-2,-1,0,+1}.
   task automatic encode(input logic [15:0] a, output logic [6:0] enm, output logic [6:0] enp,
                         output logic es, output logic eo, output logic et);
      int c;
      int t;
      c   = 0;
      enm = '0;
      enp = '0;
      for (int k = 0; k < 7; k++) begin
         t = int'(a[2*k +: 2]) + c;
         case (t)
            0: begin c = 0; end
            1: begin enp[k] = 1'b1; c = 0; end
            2: begin enm[k] = 1'b1; c = 1; end
            3: begin enm[k] = 1'b1; enp[k] = 1'b1; c = 1; end
            default: begin c = 1; end
         endcase
      end
      t  = (a[15] ? -2 : 0) + int'(a[14]) + c;
      es = (t < 0);
      eo = (t == 1) || (t == -1);
      et = (t == 2) || (t == -2);
   endtask

   function automatic int expected_latency(input logic [6:0] enm, input logic [6:0] enp,
                                           input logic eo, input logic et);
      int last;
      last = -1;
      for (int k = 0; k < 7; k++)
         if (enm[k] | enp[k]) last = k;
      if (eo | et) last = 7;
`ifdef NR4SDM_ZERO_SKIP_EN
      if (last < 0) return 1;
      return (last + 2 > 8) ? 8 : last + 2;
`else
      return (last >= -1) ? 8 : 0;
`endif
   endfunction

   task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] bv, output int exp_lat);
      logic [6:0] enm;
      logic [6:0] enp;
      logic       es, eo, et;
      encode(a, enm, enp, es, eo, et);
      exp_lat = expected_latency(enm, enp, eo, et);
      @(negedge clk);
      nm = enm; np = enp; sign = es; one = eo; two = et; b = bv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_product(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic accept_product(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_output({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
      check_output({tag, " in_ready back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_product(input string tag, input logic [15:0] a, input logic [15:0] bv,
                              input logic [31:0] expected);
      int exp_lat;
      apply_stimulus(a, bv, exp_lat);
      wait_product(tag, exp_lat);
      check_output({tag, " p"}, p, expected);
      accept_product(tag);
   endtask

   typedef struct {
      string       tag;
      logic [15:0] a;
      logic [15:0] bv;
      logic [31:0] expected;
   } vec_t;

   vec_t vecs[$] = '{
      '{"a3_b5",        16'd3,      16'd5,      32'h0000000F},
      '{"amin_bmin",    16'h8000,   16'h8000,   32'h40000000},
      '{"aneg1_b1234",  16'hFFFF,   16'd1234,   32'hFFFFFB2E},
      '{"a0_bneg5",     16'd0,      16'hFFFB,   32'h00000000},
      '{"amax_bmax",    16'h7FFF,   16'h7FFF,   32'h3FFF0001},
      '{"amin_bmax",    16'h8000,   16'h7FFF,   32'hC0008000},
      '{"a1_bneg1",     16'd1,      16'hFFFF,   32'hFFFFFFFF},
      '{"a2_bneg3",     16'd2,      16'hFFFD,   32'hFFFFFFFA}
   };

   initial begin
      int exp_lat;
      logic [15:0] ra;
      logic [15:0] rb;
      int prod;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      nm = '0; np = '0; sign = 1'b0; one = 1'b0; two = 1'b0; b = '0;
      #2;
      check_output("reset p", p, 32'd0);
      check_output("reset out_valid", 32'(out_valid), 32'd0);
      check_output("reset in_ready", 32'(in_ready), 32'd1);
      check_output("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_product(vecs[i].tag, vecs[i].a, vecs[i].bv, vecs[i].expected);

      // Backpressure: product held, new operands refused while DONE
      apply_stimulus(16'd100, 16'd3, exp_lat);
      wait_product("bp", exp_lat);
      for (int k = 0; k < 5; k++) begin
         nm = 7'h00; np = 7'h01; sign = 1'b0; one = 1'b0; two = 1'b0; b = 16'd9;
         in_valid = 1'b1;
         @(negedge clk);
         check_output("bp p stable", p, 32'd300);
         check_output("bp out_valid held", 32'(out_valid), 32'd1);
         check_output("bp in_ready low", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      accept_product("bp");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_output("bp no second start", 32'(busy), 32'd0);
         check_output("bp no second product", 32'(out_valid), 32'd0);
      end

      // Asynchronous reset in the middle of a run
      apply_stimulus(16'd3, 16'd5, exp_lat);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("midrst out_valid", 32'(out_valid), 32'd0);
      check_output("midrst p", p, 32'd0);
      check_output("midrst in_ready", 32'(in_ready), 32'd1);
      check_output("midrst busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_product("after_rst_a3_b7", 16'd3, 16'd7, 32'd21);

      // Random sweep against the bench's own integer product
      for (int k = 0; k < 1000; k++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         prod = int'($signed(ra)) * int'($signed(rb));
         run_product("sweep", ra, rb, 32'(prod));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/nr4sdm_seq_multiplier.md
Name: nr4sdm_seq_multiplier

Overview:
Sequential radix-4 partial-product accumulator that consumes the NR4SD- recoded multiplier produced by nr4sdm_encoder: nm[6:0], np[6:0], plus the Modified-Booth top digit sign/one/two. It processes one recoded digit per clock against a signed multiplicand and delivers the signed product over a valid/ready handshake. It is the downstream stage of the 16-bit NR4SD- multiplier path.

Parameters:
BW, 16, multiplicand width (signed two's complement); product width PW = BW+16
NDIG, 8, number of recoded digits (7 NR4SD- + 1 MB); fixed by the 16-bit encoder, not to be overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands (high only in IDLE)
nm  input  7  NR4SD- negative digit bits, digit j weight -2*4^j
np  input  7  NR4SD- positive digit bits, digit j weight +1*4^j
sign  input  1  MB top digit sign
one  input  1  MB top digit magnitude 1
two  input  1  MB top digit magnitude 2
b  input  BW  signed multiplicand
out_valid  output  1  product valid, held until accepted
out_ready  input  1  consumer accepts product
p  output  PW  signed product
busy  output  1  high in RUN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, p=0, out_valid=0, busy=0, in_ready=1, digit counter=0, operand registers cleared. Reset mid-RUN or mid-DONE aborts; no product emitted.
- States: IDLE -> RUN on in_valid&in_ready; RUN -> DONE after final digit; DONE -> IDLE on out_valid&out_ready.
- Capture edge (E0): latch nm, np, sign, one, two, b; clear accumulator; counter j=0.
- RUN, one digit per edge E1..E8: acc += (d_j * b) << 2j, sign-extended to PW.
- Digit j<7: d_j = np[j] - 2*nm[j], in {-2,-1,0,+1}.
- Digit 7: magnitude 2 if two, 1 if one, else 0; negated if sign. Illegal one&two=1: treated as two. sign with zero magnitude = 0.
- Negative partial product = bitwise inversion + carry-in 1 into the adder; no separate negation stage.
- Accumulator is PW bits, mod 2^PW. For BW=16 no overflow is possible.
- At edge E8, out_valid rises and p holds the final sum. Fixed latency is 8 clocks from the capture edge.
- DONE: p and out_valid are stable until out_ready; the same edge returns to IDLE, and in_ready goes high the next cycle.
- in_valid outside IDLE is ignored; operands are never overwritten in RUN or DONE.
- out_ready while out_valid=0 has no effect.
- busy = (state==RUN). p keeps its last value in IDLE.

Optional Feature:
Macro NR4SDM_ZERO_SKIP_EN.
- Defined: during RUN, if all digits j..7 are zero (nm, np, one, two above and including j), go directly to DONE on that edge. The accumulator is already final. Latency is 1..8 clocks; all-zero multiplier takes 1 clock.
- Not defined: always 8 RUN clocks, no skip logic.

Test Plan:
- A=3: nm=7'b0000001, np=7'b0000011, sign/one/two=0; b=5 -> p=32'h0000000F, out_valid 8 clocks after capture.
- A=-32768: nm=0, np=0, sign=1, two=1, one=0; b=-32768 -> p=32'h40000000.
- A=-1: nm=7'b0000001, np=7'b0000001, top digit 0; b=1234 -> p=32'hFFFFFB2E. With NR4SDM_ZERO_SKIP_EN, out_valid after 2 clocks (digit0, then skip); without it, after 8.
- Backpressure: hold out_ready=0 for 5 clocks after out_valid, pulse in_valid meanwhile -> p stable, in_ready=0, second operand not taken; accepted only after out_ready handshake.
- Reset mid-RUN: assert rst_n=0 at clock 4 of a multiply -> out_valid=0, p=0, in_ready=1 immediately; next multiply with b=7, A=3 gives p=21.
- Randomized sweep: 1000 random signed A (encoded by nr4sdm_encoder) x random b -> p equals A*b (32-bit signed) every time.
